m_ctrl: RTL
===========

Name: m_ctrl

Overview:
- Sequencing controller for the M-extension arithmetic datapath. It is the driving end of that datapath's interface.
- Accepts one RV32M operation from the core through a valid/ready handshake.
- Owns the R/D/Z working registers and drives the datapath mux selects. Runs single-pass multiplication or 32-iteration restoring division, using the datapath's subtractor sign and result.
- Returns the 32-bit result through a valid/ready output handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- DIV_ITERS, 32, number of restoring-division iterations; must equal XLEN.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  controller can accept a request; high only in IDLE.
- in_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_rs1  in  32  dividend / multiplicand.
- in_rs2  in  32  divisor / multiplier.
- flush  in  1  synchronous abort; returns to IDLE, discards the operation.
- out_valid  out  1  result available.
- out_ready  in  1  core consumes result.
- out_result  out  32  result.
- busy  out  1  state != IDLE.
- mux_multA  out  2  datapath multiplier A select: 0 R unsigned, 1 R signed, 2 zero.
- mux_multB  out  2  datapath multiplier B select: 0 D unsigned, 1 D signed, 2 zero.
- mux_div_rem  out  1  datapath divide-result select: 0 R (remainder), 1 Z (quotient).
- R  out  32  remainder / multiplicand register.
- D  out  63  divisor register (divisor aligned at [62:31]).
- Z  out  32  quotient register.
- sub_neg  in  1  sign of (R - D), 63-bit.
- sub_result  in  32  (R - D)[31:0].
- div_rem  in  32  selected R or Z.
- div_rem_neg  in  32  two's-complement negation of div_rem.
- product  in  64  multiplier product.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE.
  - R, Z, out_result = 0; D = 0.
  - out_valid = 0; busy = 0; in_ready = 1.
  - mux_multA = mux_multB = 2 (zero); mux_div_rem = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - in_ready = 1; multiplier selects = zero.
  - On in_valid: latch funct3 and the sign flags below.
  - funct3[2] = 0 -> R = rs1, D = {rs2, 31'b0}, go to MUL.
  - funct3[2] = 1 -> R = |rs1| (if signed op and rs1[31]), D = {|rs2|, 31'b0}, Z = 0, iteration counter = 0, go to DIV.
  - Unsigned ops (DIVU, REMU) use raw values, never absolute values.
- MUL (one cycle):
  - Selects by funct3: MUL 0/0; MULH 1/1; MULHSU 1/0; MULHU 0/0.
  - out_result <= product[31:0] for MUL, product[63:32] otherwise.
  - Go to DONE.
- DIV (32 cycles), each cycle:
  - If sub_neg = 0: R <= sub_result, Z <= {Z[30:0], 1}.
  - Else: Z <= {Z[30:0], 0}, R unchanged.
  - D <= D >> 1 (logical). Counter increments.
  - Leave for FIX after the 32nd iteration.
- FIX (one cycle):
  - mux_div_rem = 1 for DIV/DIVU, 0 for REM/REMU.
  - neg_q = signed op & (rs1[31] ^ rs2[31]) & (rs2 != 0).
  - neg_r = signed op & rs1[31].
  - out_result <= (DIV ? neg_q : REM ? neg_r : 0) ? div_rem_neg : div_rem.
  - Go to DONE.
- DONE:
  - out_valid = 1; out_result held stable.
  - On out_ready: go to IDLE (next request accepted no earlier than the following cycle).
- Latency: request accepted on clock edge k -> out_valid high after edge k+2 (MUL family) or k+34 (DIV family).
- Divide by zero:
  - Quotient = 0xFFFFFFFF (DIV and DIVU); remainder = rs1.
  - Produced naturally by the iteration; neg_q is suppressed.
- Overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0, with no special casing.
- flush:
  - Has priority over every transition.
  - Next state IDLE, out_valid = 0, registers untouched.
  - flush in IDLE with in_valid: request not accepted.
- Datapath inputs are ignored in IDLE and DONE.
- in_valid while busy is ignored; the request stays pending.

Test Plan:
- MULH rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001; out_valid 2 cycles after accept.
- DIV rs1 = -7 (0xFFFFFFF9), rs2 = 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; out_valid at accept + 34.
- DIVU and DIV 1234/0 -> 0xFFFFFFFF; REM -1234/0 -> 0xFFFFFB2E (rs1 unchanged).
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-pressure: out_ready held low 5 cycles in DONE -> out_valid and out_result stable; a second in_valid is not accepted until 1 cycle after the out handshake.
- flush at DIV iteration 10 -> IDLE next cycle, out_valid never asserted. resetn pulsed low mid-DIV -> all outputs at reset values immediately (asynchronous); a new MULHU afterwards completes correctly.

Source files
------------

// File: rtl/m_ctrl.sv
// Sequencing controller for the RV32M arithmetic datapath: owns R/D/Z, steers the
// multiplier and divide-result muxes, and runs single-pass MUL or 32-step restoring DIV.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// MUL   | one cycle, product captured into out_result
// DIV   | restoring-division iterations, one quotient bit per cycle
// FIX   | sign correction of quotient/remainder into out_result
// DONE  | result held until the core takes it
module m_ctrl #(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_funct3,
   input  logic [XLEN-1:0]       in_rs1,
   input  logic [XLEN-1:0]       in_rs2,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_result,
   output logic                  busy,
   output logic [1:0]            mux_multA,
   output logic [1:0]            mux_multB,
   output logic                  mux_div_rem,
   output logic [XLEN-1:0]       R,
   output logic [2*XLEN-2:0]     D,
   output logic [XLEN-1:0]       Z,
   input  logic                  sub_neg,
   input  logic [XLEN-1:0]       sub_result,
   input  logic [XLEN-1:0]       div_rem,
   input  logic [XLEN-1:0]       div_rem_neg,
   input  logic [2*XLEN-1:0]     product
);

   localparam int CW = $clog2(DIV_ITERS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      f3;
   logic            neg_q, neg_r;
   logic [CW-1:0]   cnt;
   logic            accept;

   logic            signed_op;
   logic [XLEN-1:0] abs_rs1, abs_rs2;

   // DIV and REM have funct3[0] = 0; DIVU/REMU use raw operands
   assign signed_op = in_funct3[2] & ~in_funct3[0];
   assign abs_rs1   = (signed_op & in_rs1[XLEN-1]) ? (~in_rs1 + 1'b1) : in_rs1;
   assign abs_rs2   = (signed_op & in_rs2[XLEN-1]) ? (~in_rs2 + 1'b1) : in_rs2;

   assign busy = (state != S_IDLE);

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      accept      = 1'b0;
      mux_multA   = 2'd2;
      mux_multB   = 2'd2;
      mux_div_rem = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = in_funct3[2] ? S_DIV : S_MUL;
            end
         end
         S_MUL: begin
            case (f3[1:0])
               2'b01:   begin mux_multA = 2'd1; mux_multB = 2'd1; end
               2'b10:   begin mux_multA = 2'd1; mux_multB = 2'd0; end
               default: begin mux_multA = 2'd0; mux_multB = 2'd0; end
            endcase
            state_nxt = S_DONE;
         end
         S_DIV: begin
            if (cnt == CW'(DIV_ITERS - 1)) state_nxt = S_FIX;
         end
         S_FIX: begin
            mux_div_rem = ~f3[1];
            state_nxt   = S_DONE;
         end
         S_DONE: begin
            if (out_valid && out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         out_valid  <= 1'b0;
         out_result <= '0;
         R          <= '0;
         D          <= '0;
         Z          <= '0;
         f3         <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         cnt        <= '0;
      end else begin
         state <= state_nxt;
         // valid rises one cycle after entering DONE and drops on handshake or flush
         out_valid <= (state == S_DONE) && (state_nxt == S_DONE);
         if (!flush) begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     f3    <= in_funct3;
                     neg_q <= signed_op & (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]) & (in_rs2 != '0);
                     neg_r <= signed_op & in_rs1[XLEN-1];
                     if (in_funct3[2]) begin
                        R   <= abs_rs1;
                        D   <= {abs_rs2, {(XLEN-1){1'b0}}};
                        Z   <= '0;
                        cnt <= '0;
                     end else begin
                        R <= in_rs1;
                        D <= {in_rs2, {(XLEN-1){1'b0}}};
                     end
                  end
               end
               S_MUL: begin
                  out_result <= (f3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
               end
               S_DIV: begin
                  if (!sub_neg) begin
                     R <= sub_result;
                     Z <= {Z[XLEN-2:0], 1'b1};
                  end else begin
                     Z <= {Z[XLEN-2:0], 1'b0};
                  end
                  D   <= D >> 1;
                  cnt <= cnt + 1'b1;
               end
               S_FIX: begin
                  out_result <= (f3[1] ? neg_r : neg_q) ? div_rem_neg : div_rem;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
